regfile_mp: RTL and testbench

Parametrised multi-port register file for the integer core: one write port, NUM_READ registered read ports, configurable width and depth, and a hardwired-zero entry 0. After reset it clears every entry with an internal sweep, signalled by `ready`. It sits between decode (read addresses) and writeback (write port). Optional same-cycle write-to-read bypass is compiled in by macro.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_clear_ctrl.sv | 74 +++++++
 rtl/regfile_mp.sv | 133 +++++++++++++
 tb/tb_regfile_mp.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared types and constants for the multi-port register file.
//   state_t       : clear-sweep controller states (ST_CLEAR, ST_READY)
//   DEF_*         : default width / depth / read-port count
//   addr_width()  : address bits needed to index DEPTH entries
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_NUM_READ = 2;

    // Never return 0 so that a 2-entry file still gets a 1-bit address.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl
// Post-reset clear sweep for the register file. While in ST_CLEAR it
// presents one entry address per cycle for the storage to zero, then
// settles in ST_READY until the next reset.
// Ports:
//   i_clk      : rising-edge clock
//   i_reset_n  : asynchronous active-low reset
//   o_ready    : high once every entry has been cleared
//   o_clr_en   : clear write strobe for the storage this cycle
//   o_clr_addr : entry being cleared this cycle
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    output logic          o_ready,
    output logic          o_clr_en,
    output logic [AW-1:0] o_clr_addr
);

    localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic          w_clr_en;
    logic [AW-1:0] r_clr_cnt;

    // State register; reset always restarts the sweep.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and clear strobe. The last entry is cleared on the same
    // edge that moves to ST_READY, so the sweep is exactly DEPTH cycles.
    always_comb begin
        w_next_state = r_state;
        w_clr_en     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_en = 1'b1;
                if (r_clr_cnt == LAST_ENTRY) begin
                    w_next_state = ST_READY;
                end
            end
            ST_READY: begin
                w_next_state = ST_READY;
            end
            default: begin
                w_next_state = ST_CLEAR;
            end
        endcase
    end

    // Clear counter only advances while sweeping.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_clr_cnt <= '0;
        end else if (w_clr_en && (r_clr_cnt != LAST_ENTRY)) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    assign o_ready    = (r_state == ST_READY);
    assign o_clr_en   = w_clr_en;
    assign o_clr_addr = r_clr_cnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port register file: one write port, NUM_READ registered read
// ports, optional hardwired-zero entry 0 and a post-reset clear sweep.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read of the
// address being written in the same cycle returns the new write data.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   rd_addr  : NUM_READ packed read addresses, port i at [i*AW +: AW]
//   rd_data  : NUM_READ packed registered read data, port i at [i*DATA_W +: DATA_W]
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   ready    : high once the clear sweep has finished
//   wr_drop  : one-cycle pulse after a discarded write
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_READ*AW-1:0]     rd_addr,
    output logic [NUM_READ*DATA_W-1:0] rd_data,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       ready,
    output logic                       wr_drop
);

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic                       w_ready;
    logic                       w_clr_en;
    logic [AW-1:0]              w_clr_addr;

    logic [DATA_W-1:0]          r_mem [DEPTH];
    logic                       w_wr_in_range;
    logic                       w_wr_zero;
    logic                       w_user_we;
    logic                       w_drop_next;
    logic                       w_mem_we;
    logic [AW-1:0]              w_mem_waddr;
    logic [DATA_W-1:0]          w_mem_wdata;

    logic [AW-1:0]              w_ra      [NUM_READ];
    logic [DATA_W-1:0]          w_rd_next [NUM_READ];
    logic [NUM_READ*DATA_W-1:0] r_rd_data;
    logic                       r_wr_drop;

    regfile_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_ctrl (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .o_ready    (w_ready),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr)
    );

    // A user write lands only when ready, in range and not aimed at the
    // hardwired-zero entry. Zero-entry writes vanish without a drop pulse.
    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_V);
    assign w_wr_zero     = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_user_we     = w_ready && wr_en && w_wr_in_range && !w_wr_zero;
    assign w_drop_next   = wr_en && (!w_ready || !w_wr_in_range);

    // The sweep and user writes are mutually exclusive (ready vs clearing),
    // so a simple mux shares the single storage write port.
    assign w_mem_we    = w_clr_en | w_user_we;
    assign w_mem_waddr = w_clr_en ? w_clr_addr : wr_addr;
    assign w_mem_wdata = w_clr_en ? '0 : wr_data;

    // Storage array; contents are defined by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Read-side selection per port: out-of-range and zero-entry reads give
    // 0; with the bypass compiled in, a matching accepted write wins.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            w_ra[i]      = rd_addr[i*AW +: AW];
            w_rd_next[i] = '0;
            if (({1'b0, w_ra[i]} < DEPTH_V) &&
                !((ZERO_REG != 0) && (w_ra[i] == '0))) begin
                w_rd_next[i] = r_mem[w_ra[i]];
            end
`ifdef REGFILE_BYPASS_EN
            if (w_user_we && (w_ra[i] == wr_addr)) begin
                w_rd_next[i] = wr_data;
            end
`else
`endif
        end
    end

    // Registered read data, held at zero until the sweep finishes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (!w_ready) begin
            r_rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM_READ; i++) begin
                r_rd_data[i*DATA_W +: DATA_W] <= w_rd_next[i];
            end
        end
    end

    // Drop flag reports the previous cycle's discarded write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_drop_next;
        end
    end

    assign rd_data = r_rd_data;
    assign ready   = w_ready;
    assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp: a 32-entry instance for reset, sweep,
// read/write, zero entry and bypass behaviour, plus a 24-entry instance
// for out-of-range addressing. Honours REGFILE_BYPASS_EN if defined.
module tb_regfile_mp;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        edrop;
    } vec_t;

    logic        clk;
    logic        reset_n;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        ready;
    logic        wr_drop;

    logic [9:0]  rd_addr24;
    logic [63:0] rd_data24;
    logic        wr_en24;
    logic [4:0]  wr_addr24;
    logic [31:0] wr_data24;
    logic        ready24;
    logic        wr_drop24;

    int          total;
    int          passed;
    vec_t        vecs [9];
    logic [31:0] bypassExp;

    regfile_mp #(
        .DATA_W   (32),
        .DEPTH    (32),
        .NUM_READ (2),
        .ZERO_REG (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready),
        .wr_drop (wr_drop)
    );

    regfile_mp #(
        .DATA_W   (32),
        .DEPTH    (24),
        .NUM_READ (2),
        .ZERO_REG (1)
    ) dut24 (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_addr (rd_addr24),
        .rd_data (rd_data24),
        .wr_en   (wr_en24),
        .wr_addr (wr_addr24),
        .wr_data (wr_data24),
        .ready   (ready24),
        .wr_drop (wr_drop24)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives the 32-entry instance, then advances one edge and settles.
    task automatic applyStimulus(input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_addr = {ra1, ra0};
        @(posedge clk);
        #1;
    endtask

    // Single comparison with pass/total bookkeeping.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd1,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd30, 5'd0,  32'h0,        32'h0,        1'b0};
        vecs[5] = '{1'b1, 5'd7,  32'h12345678, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 32'h12345678, 32'hA5A5A5A5, 1'b0};
        vecs[7] = '{1'b1, 5'd5,  32'h11111111, 5'd7,  5'd0,  32'h12345678, 32'h0,        1'b0};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'h11111111, 32'h12345678, 1'b0};

        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        wr_en24   = 1'b0;
        wr_addr24 = '0;
        wr_data24 = '0;
        rd_addr24 = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready",   {31'b0, ready},    32'h0);
        checkOutput("rst_wr_drop", {31'b0, wr_drop},  32'h0);
        checkOutput("rst_rd0",     rd_data[31:0],     32'h0);
        checkOutput("rst_rd1",     rd_data[63:32],    32'h0);
        checkOutput("rst_ready24", {31'b0, ready24},  32'h0);

        // Sweep: ready rises exactly DEPTH edges after release; a write
        // attempted while clearing is dropped.
        @(negedge clk);
        reset_n = 1'b1;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            applyStimulus(cyc == 5, 5'd3, 32'h0BADF00D, 5'd3, 5'd3);
            checkOutput($sformatf("sweep_ready_c%0d", cyc), {31'b0, ready},
                        (cyc >= 32) ? 32'h1 : 32'h0);
            checkOutput($sformatf("sweep_drop_c%0d", cyc), {31'b0, wr_drop},
                        (cyc == 5) ? 32'h1 : 32'h0);
            checkOutput($sformatf("sweep_ready24_c%0d", cyc), {31'b0, ready24},
                        (cyc >= 24) ? 32'h1 : 32'h0);
        end

        // Every entry reads zero after the sweep.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            checkOutput($sformatf("clr_rd0_a%0d", i), rd_data[31:0],  32'h0);
            checkOutput($sformatf("clr_rd1_a%0d", 31 - i), rd_data[63:32], 32'h0);
        end

        // Directed read/write vectors.
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra0, vecs[v].ra1);
            checkOutput($sformatf("vec%0d_rd0", v), rd_data[31:0],  vecs[v].e0);
            checkOutput($sformatf("vec%0d_rd1", v), rd_data[63:32], vecs[v].e1);
            checkOutput($sformatf("vec%0d_drop", v), {31'b0, wr_drop}, {31'b0, vecs[v].edrop});
        end

        // Same-cycle read and write of entry 5 (holds 0x11111111).
`ifdef REGFILE_BYPASS_EN
        bypassExp = 32'h22222222;
`else
        bypassExp = 32'h11111111;
`endif
        applyStimulus(1'b1, 5'd5, 32'h22222222, 5'd5, 5'd5);
        checkOutput("same_cycle_rd0", rd_data[31:0],  bypassExp);
        checkOutput("same_cycle_rd1", rd_data[63:32], bypassExp);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checkOutput("after_write_rd0", rd_data[31:0],  32'h22222222);
        checkOutput("after_write_rd1", rd_data[63:32], 32'h22222222);

        // Out-of-range handling on the 24-entry instance.
        wr_en24 = 1'b1; wr_addr24 = 5'd30; wr_data24 = 32'h5; rd_addr24 = {5'd30, 5'd30};
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checkOutput("oor_drop",  {31'b0, wr_drop24}, 32'h1);
        checkOutput("oor_rd0",   rd_data24[31:0],    32'h0);
        wr_en24 = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checkOutput("oor_drop_end", {31'b0, wr_drop24}, 32'h0);
        checkOutput("oor_rd1",      rd_data24[63:32],   32'h0);
        wr_en24 = 1'b1; wr_addr24 = 5'd23; wr_data24 = 32'h5; rd_addr24 = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checkOutput("last_entry_drop", {31'b0, wr_drop24}, 32'h0);
        wr_en24 = 1'b0; rd_addr24 = {5'd0, 5'd23};
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checkOutput("last_entry_rd", rd_data24[31:0], 32'h5);

        // Asynchronous reset clears outputs without waiting for an edge.
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_rd0",   rd_data[31:0], 32'h0);
        checkOutput("async_rst_ready", {31'b0, ready}, 32'h0);

        // Reset again in the middle of a sweep; the sweep restarts in full.
        @(negedge clk);
        reset_n = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        end
        checkOutput("mid_sweep_ready", {31'b0, ready}, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", {31'b0, ready}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
            if (cyc >= 31) begin
                checkOutput($sformatf("resweep_ready_c%0d", cyc), {31'b0, ready},
                            (cyc == 32) ? 32'h1 : 32'h0);
            end
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        checkOutput("resweep_rd7", rd_data[31:0],  32'h0);
        checkOutput("resweep_rd5", rd_data[63:32], 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
